tx_engine: RTL and testbench
============================

Name: tx_engine

Overview:
UART transmitter, the sending half of the serial link. It takes a byte written by the TramelBlaze and serialises it on TxD: one start bit, 7 or 8 data bits LSB first, optional parity, then stop/mark padding. Framing controls (bit8, pen, ohel) have the same meaning as on the receive side, so both ends share one configuration. Baud timing is generated internally from a programmable bit-time count.

Parameters:
BAUD_W, 19, width of baud_k count input

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  write strobe from TramelBlaze; accepted only when txrdy=1
out_port  input  8  data byte to transmit
bit8  input  1  1 = 8 data bits, 0 = 7 data bits (out_port[7] ignored)
pen  input  1  parity enable
ohel  input  1  parity sense: 1 = odd, 0 = even
baud_k  input  BAUD_W  clocks per bit time; values below 2 are treated as 2
tx  output  1  serial data out (TxD); idle/mark = 1
txrdy  output  1  1 = idle and ready for load; 0 = frame in progress

Behaviour:
- Reset (synchronous, highest priority, also mid-frame): shift register = all 1s, so tx=1. txrdy=1. doit=0. Baud counter = 0. Bit counter = 0. Any frame in progress is abandoned at the reset edge.
- Accept: on an edge with load=1 and txrdy=1:
  - Latch the 11-bit frame into the shift register.
  - doit=1, txrdy=0.
  - Clear the baud and bit counters.
  - Latch baud_k. Config and data changes after this edge have no effect on the current frame.
- load while txrdy=0 is ignored. It is not queued, and no overflow flag exists.
- Frame is always 11 bit times, LSB first: [0]=0 (start), [7:1]=out_port[6:0]. Bits [10:8] by mode:
  - bit8=1, pen=1: d7, par, 1
  - bit8=1, pen=0: d7, 1, 1
  - bit8=0, pen=1: par, 1, 1
  - bit8=0, pen=0: 1, 1, 1
- Parity: par = XOR(out_port[6:0]) ^ (bit8 ? out_port[7] : 0) ^ ohel.
- tx = shift_reg[0]. tx goes low in the cycle after the accepting edge (edge E0).
- Baud counter:
  - Runs only while doit=1.
  - btu is asserted when the count equals bit time − 1; the counter then wraps to 0.
- On each btu:
  - Shift right, filling 1 at bit 10.
  - Increment the bit counter.
- Completion: the btu that takes the bit counter to 11 ends the frame. On that edge: doit=0, txrdy=1, counters cleared, tx=1.
- Total busy time is exactly 11 × bit time clocks from E0. txrdy is 0 for exactly that many cycles.
- Simultaneous load and completion edge: load is ignored, because txrdy is still 0 in that cycle. A load on the following cycle is accepted, giving back-to-back frames with no extra idle bit time.
- While idle, tx=1 continuously. Counters hold at 0.

Test Plan:
1. Reset → tx=1, txrdy=1. Hold idle for 50 cycles → tx stays 1 and no counter activity.
2. baud_k=4, bit8=1, pen=1, ohel=0, load out_port=0x55 → tx sequence per 4-clk bit: 0,1,0,1,0,1,0,1,0,0,1. txrdy low exactly 44 cycles.
3. baud_k=4, bit8=0, pen=1, ohel=1, load 0xC1 → data bits 1,0,0,0,0,0,1 (bit7 ignored), par=1. Frame: 0,1,0,0,0,0,0,1,1,1,1.
4. bit8=0, pen=0, baud_k=3, load 0x7F → frame 0 followed by ten 1s. Also pulse load again at cycle 10 → second load ignored and frame unchanged.
5. Back-to-back: load 0xA5, then load 0x3C in the first cycle txrdy=1 (8N, baud_k=2) → second start bit begins immediately after the first frame's final bit. A load on the completion edge itself is ignored.
6. Reset asserted mid-frame (bit 5) → next cycle tx=1, txrdy=1. A new load afterwards produces a correct full frame. baud_k=0 behaves identically to baud_k=2.

Source files
------------

// File: rtl/tx_engine.sv
// UART transmitter: serialises one byte as an 11-bit-time frame on tx.
// Start bit, 7 or 8 data bits LSB first, optional parity, then mark padding.
module tx_engine #(
  parameter int unsigned BAUD_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic              bit8,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              tx,
  output logic              txrdy
);

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned BITC_W  = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state, state_nxt;
  logic [FRAME_W-1:0] shift_reg, shift_nxt;
  logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
  logic [BAUD_W-1:0]  bt_lat, bt_nxt;
  logic [BITC_W-1:0]  bit_cnt, bit_nxt;
  logic               txrdy_nxt;

  logic               doit_c;
  logic               btu_c;
  logic               par_c;
  logic [2:0]         hi_c;
  logic [FRAME_W-1:0] frame_c;
  logic [BAUD_W-1:0]  bt_c;

  // Frame assembly from the live inputs; only used on the accepting edge.
  always_comb begin
    par_c = (^out_port[6:0]) ^ (bit8 & out_port[7]) ^ ohel;
    case ({bit8, pen})
      2'b11:   hi_c = {1'b1, par_c, out_port[7]};
      2'b10:   hi_c = {1'b1, 1'b1, out_port[7]};
      2'b01:   hi_c = {1'b1, 1'b1, par_c};
      default: hi_c = 3'b111;
    endcase
    frame_c = {hi_c, out_port[6:0], 1'b0};
    bt_c    = (baud_k < BAUD_W'(2)) ? BAUD_W'(2) : baud_k;
  end

  assign doit_c = (state == SEND);
  assign btu_c  = doit_c && (baud_cnt == (bt_lat - BAUD_W'(1)));

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    baud_nxt  = baud_cnt;
    bt_nxt    = bt_lat;
    bit_nxt   = bit_cnt;
    txrdy_nxt = txrdy;
    case (state)
      IDLE: begin
        if (load && txrdy) begin
          state_nxt = SEND;
          shift_nxt = frame_c;
          baud_nxt  = '0;
          bit_nxt   = '0;
          bt_nxt    = bt_c;
          txrdy_nxt = 1'b0;
        end
      end
      SEND: begin
        if (btu_c) begin
          baud_nxt = '0;
          if (bit_cnt == BITC_W'(FRAME_W - 1)) begin
            state_nxt = IDLE;
            shift_nxt = '1;
            bit_nxt   = '0;
            txrdy_nxt = 1'b1;
          end else begin
            shift_nxt = {1'b1, shift_reg[FRAME_W-1:1]};
            bit_nxt   = bit_cnt + BITC_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        shift_nxt = '1;
        baud_nxt  = '0;
        bit_nxt   = '0;
        txrdy_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '1;
      baud_cnt  <= '0;
      bt_lat    <= BAUD_W'(2);
      bit_cnt   <= '0;
      txrdy     <= 1'b1;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      baud_cnt  <= baud_nxt;
      bt_lat    <= bt_nxt;
      bit_cnt   <= bit_nxt;
      txrdy     <= txrdy_nxt;
    end
  end

  assign tx = shift_reg[0];

endmodule

// File: tb/tb_tx_engine.sv
// Directed bench for tx_engine: table of frames with hand-computed bit patterns
// plus hand-written reset, idle, ignored-load and back-to-back sequences.
module tb_tx_engine;

  localparam int unsigned BAUD_W = 19;
  localparam int NV = 8;

  typedef struct {
    logic [7:0]        data;
    logic              b8;
    logic              pe;
    logic              odd;
    logic [BAUD_W-1:0] baud;
    logic [10:0]       frame;    // [0] = start bit, sent first
    int                pulse_at; // cycle of an extra load that must be ignored, -1 = none
    bit                chain;    // next vector is loaded on the completion edge
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [7:0]        out_port;
  logic              bit8;
  logic              pen;
  logic              ohel;
  logic [BAUD_W-1:0] baud_k;
  logic              tx;
  logic              txrdy;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];

  tx_engine #(.BAUD_W(BAUD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .out_port (out_port),
    .bit8     (bit8),
    .pen      (pen),
    .ohel     (ohel),
    .baud_k   (baud_k),
    .tx       (tx),
    .txrdy    (txrdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    out_port = v.data;
    bit8     = v.b8;
    pen      = v.pe;
    ohel     = v.odd;
    baud_k   = v.baud;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (txrdy !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(txrdy), 32'd1);
  endtask

  initial begin
    int   bad;
    int   busy;
    int   k;
    bit   prev_chain;
    vec_t v;
    logic [10:0] obs;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 19'd4, 11'h4AA, -1, 1'b0};
    vecs[1] = '{8'hC1, 1'b0, 1'b1, 1'b1, 19'd4, 11'h782, -1, 1'b0};
    vecs[2] = '{8'h7F, 1'b0, 1'b0, 1'b0, 19'd3, 11'h7FE, 10, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b0, 19'd2, 11'h74A, -1, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 19'd2, 11'h678, -1, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 1'b1, 1'b1, 19'd0, 11'h72C, -1, 1'b0};
    vecs[6] = '{8'h96, 1'b1, 1'b1, 1'b1, 19'd2, 11'h72C, -1, 1'b0};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b1, 19'd1, 11'h600, -1, 1'b0};

    reset = 1'b1;
    load = 1'b0;
    out_port = 8'h00;
    bit8 = 1'b1;
    pen = 1'b0;
    ohel = 1'b0;
    baud_k = 19'd4;

    repeat (2) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset txrdy", 32'(txrdy), 32'd1);
    reset = 1'b0;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || txrdy !== 1'b1) bad++;
    end
    check("idle 50 cycles", 32'(bad), 32'd0);

    // Abort a frame at bit 5 (a zero bit of 0xAA) with reset.
    out_port = 8'hAA;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (5 * 4 + 2) @(negedge clk);
    check("mid-frame bit5 tx", 32'(tx), 32'd0);
    check("mid-frame txrdy", 32'(txrdy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid-frame reset tx", 32'(tx), 32'd1);
    check("mid-frame reset txrdy", 32'(txrdy), 32'd1);
    reset = 1'b0;

    prev_chain = 1'b0;
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      k = (v.baud < 19'd2) ? 2 : int'(v.baud);
      bad = 0;
      busy = 0;
      obs = '0;
      if (!prev_chain) begin
        wait_idle($sformatf("vec%0d ready", i));
        @(negedge clk);
        drive(v);
        load = 1'b1;
      end
      @(posedge clk);
      #1;
      // Scramble inputs after the accepting edge; the frame must not change.
      load = 1'b0;
      out_port = ~v.data;
      bit8 = ~v.b8;
      pen = ~v.pe;
      ohel = ~v.odd;
      baud_k = 19'd7;
      for (int c = 0; c < 11 * k; c++) begin
        @(negedge clk);
        if (tx !== v.frame[c / k]) bad++;
        obs[c / k] = tx;
        if (txrdy === 1'b0) busy++;
        if (c == v.pulse_at) begin
          load = 1'b1;
          out_port = 8'h00;
        end
        if (c == v.pulse_at + 1) load = 1'b0;
        if (v.chain && c == 11 * k - 1) begin
          drive(vecs[i + 1]);
          load = 1'b1;
        end
      end
      @(negedge clk);
      check($sformatf("vec%0d done tx", i), 32'(tx), 32'd1);
      check($sformatf("vec%0d done txrdy", i), 32'(txrdy), 32'd1);
      check($sformatf("vec%0d frame", i), 32'(obs), 32'(v.frame));
      check($sformatf("vec%0d bad cycles", i), 32'(bad), 32'd0);
      check($sformatf("vec%0d busy cycles", i), 32'(busy), 32'(11 * k));
      prev_chain = v.chain;
    end

    @(negedge clk);
    check("final idle tx", 32'(tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
